mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline. Sits between the EX/MEM register and the writeback stage, and contains the MEM/WB pipeline register that the writeback stage consumes.
- Drives a single-port data memory through a req/ready handshake.
- Formats load data (byte/half extraction, sign/zero extension) and store data (lane replication, byte enables).
- Stalls upstream while a memory access is outstanding.

Parameters:
DMEM_ADDR_W, 32, width of dmem_addr; the low DMEM_ADDR_W bits of the ALU result are used.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
ex_mem_valid  in  1  instruction in EX/MEM is valid
ex_mem_pc_4  in  32  PC+4 of the instruction
ex_mem_alu_result  in  32  ALU result / effective address
ex_mem_rs2_data  in  32  store data
ex_mem_rd  in  5  destination register
ex_mem_reg_write_en  in  1  register write enable
ex_mem_mem_to_reg_sel  in  2  writeback select (00 ALU, 01 mem, 10 PC+4)
ex_mem_mem_read  in  1  load
ex_mem_mem_write  in  1  store
ex_mem_funct3  in  3  size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
dmem_req  out  1  memory request
dmem_we  out  1  write request
dmem_addr  out  DMEM_ADDR_W  word-aligned address (bits [1:0] = 0)
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-aligned store data
dmem_ready  in  1  request accepted/completed this cycle
dmem_rdata  in  32  read word, valid when dmem_ready is high on a read
mem_stall  out  1  hold PC/IF/ID/EX and EX/MEM
mem_wb_pc_4  out  32  registered
mem_wb_alu_result  out  32  registered
mem_wb_mem_read_data  out  32  registered, already extended
mem_wb_rd  out  5  registered
mem_wb_reg_write_en  out  1  registered
mem_wb_mem_to_reg_sel  out  2  registered
mem_wb_misaligned  out  1  registered fault flag for the instruction

Behaviour:
- Reset (rst=1 at a clk edge): all mem_wb_* outputs go to 0, FSM goes to IDLE. dmem_req and mem_stall are 0 while rst is high. An outstanding request is abandoned, and dmem must tolerate this.
- Access condition: acc = ex_mem_valid & (mem_read | mem_write).
- Misalignment:
  - half: addr[0] != 0.
  - word: addr[1:0] != 0.
  - A misaligned access issues no dmem_req and completes immediately.
  - It registers mem_wb_misaligned=1 and mem_wb_reg_write_en=0.
- Store formatting:
  - sb: wdata = {4{rs2[7:0]}}, be = 0001 << addr[1:0].
  - sh: wdata = {2{rs2[15:0]}}, be = addr[1] ? 1100 : 0011.
  - sw: wdata = rs2, be = 1111.
- Loads: be = 1111. The byte or half is selected from dmem_rdata by addr[1:0], then sign- or zero-extended per funct3. An undefined funct3 is treated as a word.
- FSM states: IDLE, WAIT.
  - IDLE: if acc & aligned, assert dmem_req (combinational from the EX/MEM inputs).
    - If dmem_ready=1 the same cycle, the access completes, mem_stall=0, and state stays IDLE.
    - Otherwise mem_stall=1 and state goes to WAIT.
  - WAIT: dmem_req=1 with identical address/data/be; EX/MEM is held by the stall.
    - mem_stall = ~dmem_ready.
    - On dmem_ready, the access completes and state goes to IDLE.
- MEM/WB register update each cycle:
  - Completion or non-memory instruction: load all fields from EX/MEM. mem_read_data takes the extracted load data, or 0 for non-loads. reg_write_en = ex_mem_valid & ex_mem_reg_write_en & ~misaligned.
  - Stall cycle (mem_stall=1): insert a bubble, i.e. reg_write_en=0 and misaligned=0. Other fields are don't-care and are held.
  - ex_mem_valid=0: bubble.
- Latency:
  - Non-memory instruction: 1 cycle to MEM/WB.
  - Memory access: 1 + N cycles, where N is the number of cycles dmem_ready is low.
- Stores: reg_write_en follows ex_mem (normally 0). dmem_rdata is ignored.
- Simultaneous mem_read & mem_write: treated as a load; dmem_we=0.

Decomposition:
- Shared package: funct3 load/store encodings, mem_to_reg_sel encodings (ALU/MEM/PC4), FSM state encoding.
- Natural sub-module: mem_data_align. It is combinational store lane/byte-enable generation plus load extract/extend, and can be unit-tested on its own.

Test Plan:
- ALU op (rd=5, alu_result=0x1234, sel=00, no mem access) -> next cycle mem_wb_rd=5, alu_result=0x1234, reg_write_en=1; dmem_req never asserted.
- lb at addr 0x103, dmem_rdata=0x80FF_1122, ready the same cycle -> mem_read_data=0xFFFF_FF80, mem_stall=0; lbu at the same address -> 0x0000_0080.
- sh rs2=0xAAAA_BEEF at addr 0x202 -> dmem_addr=0x200, be=1100, wdata=0xBEEF_BEEF, we=1.
- lw with dmem_ready low for 3 cycles -> mem_stall high exactly 3 cycles, dmem_req/addr stable, 3 bubbles into MEM/WB (reg_write_en=0), then the data is registered.
- lw at 0x102 -> no dmem_req, mem_wb_misaligned=1, reg_write_en=0.
- rst asserted during WAIT -> next cycle state IDLE, dmem_req=0, mem_stall=0, all mem_wb_* = 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the RV32I memory-access stage: funct3 sizes,
// writeback select values and the MEM FSM states.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_PC4 = 2'b10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    // funct3[2] is the unsigned flag; any size code other than b/h is a word.
    function automatic size_e access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   access_size = SZ_BYTE;
            2'b01:   access_size = SZ_HALF;
            default: access_size = SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_data_align.sv
// Combinational data formatting: store lane replication / byte enables and
// load byte/half extraction with sign or zero extension.
module mem_data_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] store_wdata,
    output logic [3:0]  store_be,
    output logic [31:0] load_data
);

    size_e       size;
    logic [31:0] shifted;

    assign size    = access_size(funct3);
    assign shifted = load_word >> {addr_lo, 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign store_wdata[8*gi +: 8] =
                (size == SZ_BYTE) ? store_data[7:0] :
                (size == SZ_HALF) ? store_data[8*(gi%2) +: 8] :
                                    store_data[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        store_be  = 4'b1111;
        load_data = load_word;
        case (size)
            SZ_BYTE: begin
                store_be  = 4'b0001 << addr_lo;
                load_data = {{24{shifted[7] & ~funct3[2]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                store_be  = addr_lo[1] ? 4'b1100 : 4'b0011;
                load_data = {{16{shifted[15] & ~funct3[2]}}, shifted[15:0]};
            end
            default: begin
                store_be  = 4'b1111;
                load_data = load_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: drives the data memory over req/ready, stalls upstream
// while an access is outstanding, and holds the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DMEM_ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_mem_valid,
    input  logic [31:0]            ex_mem_pc_4,
    input  logic [31:0]            ex_mem_alu_result,
    input  logic [31:0]            ex_mem_rs2_data,
    input  logic [4:0]             ex_mem_rd,
    input  logic                   ex_mem_reg_write_en,
    input  logic [1:0]             ex_mem_mem_to_reg_sel,
    input  logic                   ex_mem_mem_read,
    input  logic                   ex_mem_mem_write,
    input  logic [2:0]             ex_mem_funct3,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [DMEM_ADDR_W-1:0] dmem_addr,
    output logic [3:0]             dmem_be,
    output logic [31:0]            dmem_wdata,
    input  logic                   dmem_ready,
    input  logic [31:0]            dmem_rdata,
    output logic                   mem_stall,
    output logic [31:0]            mem_wb_pc_4,
    output logic [31:0]            mem_wb_alu_result,
    output logic [31:0]            mem_wb_mem_read_data,
    output logic [4:0]             mem_wb_rd,
    output logic                   mem_wb_reg_write_en,
    output logic [1:0]             mem_wb_mem_to_reg_sel,
    output logic                   mem_wb_misaligned
);

    logic        acc, is_load, is_store, misaligned;
    logic [1:0]  addr_lo;
    logic [31:0] store_wdata, load_data;
    logic [3:0]  store_be;
    logic [0:0]  state_q, state_d;

    logic [31:0] pc_4_q, pc_4_d, alu_result_q, alu_result_d;
    logic [31:0] read_data_q, read_data_d;
    logic [4:0]  rd_q, rd_d;
    logic [1:0]  sel_q, sel_d;
    logic        reg_write_en_q, reg_write_en_d, misaligned_q, misaligned_d;

    assign addr_lo  = ex_mem_alu_result[1:0];
    assign acc      = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);
    assign is_load  = ex_mem_mem_read;
    assign is_store = ex_mem_mem_write & ~ex_mem_mem_read;

    always_comb begin
        case (access_size(ex_mem_funct3))
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = acc & addr_lo[0];
            default: misaligned = acc & (|addr_lo);
        endcase
    end

    mem_data_align u_align (
        .funct3      (ex_mem_funct3),
        .addr_lo     (addr_lo),
        .store_data  (ex_mem_rs2_data),
        .load_word   (dmem_rdata),
        .store_wdata (store_wdata),
        .store_be    (store_be),
        .load_data   (load_data)
    );

    assign dmem_we    = dmem_req & is_store;
    assign dmem_addr  = {ex_mem_alu_result[DMEM_ADDR_W-1:2], 2'b00};
    assign dmem_be    = is_load ? 4'b1111 : store_be;
    assign dmem_wdata = store_wdata;

    // EX/MEM is frozen by the stall during WAIT, so the request fields stay put.
    always_comb begin
        dmem_req = 1'b0;
        state_d  = state_q;
        if (!rst) begin
            dmem_req = (state_q == ST_WAIT) | (acc & ~misaligned);
            case (state_q)
                ST_IDLE: if (dmem_req && !dmem_ready) state_d = ST_WAIT;
                ST_WAIT: if (dmem_ready) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
        mem_stall = dmem_req & ~dmem_ready;
    end

    always_comb begin
        pc_4_d         = pc_4_q;
        alu_result_d   = alu_result_q;
        read_data_d    = read_data_q;
        rd_d           = rd_q;
        sel_d          = sel_q;
        reg_write_en_d = 1'b0;
        misaligned_d   = 1'b0;
        if (!mem_stall) begin
            pc_4_d         = ex_mem_pc_4;
            alu_result_d   = ex_mem_alu_result;
            read_data_d    = (acc && is_load && !misaligned) ? load_data : 32'h0;
            rd_d           = ex_mem_rd;
            sel_d          = ex_mem_mem_to_reg_sel;
            reg_write_en_d = ex_mem_valid & ex_mem_reg_write_en & ~misaligned;
            misaligned_d   = misaligned;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            pc_4_q         <= '0;
            alu_result_q   <= '0;
            read_data_q    <= '0;
            rd_q           <= '0;
            sel_q          <= '0;
            reg_write_en_q <= 1'b0;
            misaligned_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_4_q         <= pc_4_d;
            alu_result_q   <= alu_result_d;
            read_data_q    <= read_data_d;
            rd_q           <= rd_d;
            sel_q          <= sel_d;
            reg_write_en_q <= reg_write_en_d;
            misaligned_q   <= misaligned_d;
        end
    end

    assign mem_wb_pc_4           = pc_4_q;
    assign mem_wb_alu_result     = alu_result_q;
    assign mem_wb_mem_read_data  = read_data_q;
    assign mem_wb_rd             = rd_q;
    assign mem_wb_reg_write_en   = reg_write_en_q;
    assign mem_wb_mem_to_reg_sel = sel_q;
    assign mem_wb_misaligned     = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized instructions,
// each cycle compared against an instruction-level reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_mem_valid;
    logic [31:0] ex_mem_pc_4, ex_mem_alu_result, ex_mem_rs2_data;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_reg_write_en;
    logic [1:0]  ex_mem_mem_to_reg_sel;
    logic        ex_mem_mem_read, ex_mem_mem_write;
    logic [2:0]  ex_mem_funct3;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic [31:0] mem_wb_pc_4, mem_wb_alu_result, mem_wb_mem_read_data;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_reg_write_en;
    logic [1:0]  mem_wb_mem_to_reg_sel;
    logic        mem_wb_misaligned;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        rwe;
        logic [1:0]  sel;
        logic        rd_en;
        logic        wr_en;
        logic [2:0]  f3;
    } instr_t;

    mem_stage #(.DMEM_ADDR_W(32)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .ex_mem_valid          (ex_mem_valid),
        .ex_mem_pc_4           (ex_mem_pc_4),
        .ex_mem_alu_result     (ex_mem_alu_result),
        .ex_mem_rs2_data       (ex_mem_rs2_data),
        .ex_mem_rd             (ex_mem_rd),
        .ex_mem_reg_write_en   (ex_mem_reg_write_en),
        .ex_mem_mem_to_reg_sel (ex_mem_mem_to_reg_sel),
        .ex_mem_mem_read       (ex_mem_mem_read),
        .ex_mem_mem_write      (ex_mem_mem_write),
        .ex_mem_funct3         (ex_mem_funct3),
        .dmem_req              (dmem_req),
        .dmem_we               (dmem_we),
        .dmem_addr             (dmem_addr),
        .dmem_be               (dmem_be),
        .dmem_wdata            (dmem_wdata),
        .dmem_ready            (dmem_ready),
        .dmem_rdata            (dmem_rdata),
        .mem_stall             (mem_stall),
        .mem_wb_pc_4           (mem_wb_pc_4),
        .mem_wb_alu_result     (mem_wb_alu_result),
        .mem_wb_mem_read_data  (mem_wb_mem_read_data),
        .mem_wb_rd             (mem_wb_rd),
        .mem_wb_reg_write_en   (mem_wb_reg_write_en),
        .mem_wb_mem_to_reg_sel (mem_wb_mem_to_reg_sel),
        .mem_wb_misaligned     (mem_wb_misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    // Access width in bytes; anything not byte/half is a word.
    function automatic int ref_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a, input logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * a);
        case (f3)
            3'b000:  return (v[7:0] >= 8'd128) ? 32'(v[7:0]) - 32'd256 : 32'(v[7:0]);
            3'b100:  return 32'(v[7:0]);
            3'b001:  return (v[15:0] >= 16'd32768) ? 32'(v[15:0]) - 32'd65536 : 32'(v[15:0]);
            3'b101:  return 32'(v[15:0]);
            default: return w;
        endcase
    endfunction

    task automatic check_wb_zero(input string tag);
        chk({tag, "_pc4"}, mem_wb_pc_4, 32'h0);
        chk({tag, "_alu"}, mem_wb_alu_result, 32'h0);
        chk({tag, "_rdata"}, mem_wb_mem_read_data, 32'h0);
        chk({tag, "_rd"}, 32'(mem_wb_rd), 32'h0);
        chk({tag, "_rwe"}, 32'(mem_wb_reg_write_en), 32'h0);
        chk({tag, "_sel"}, 32'(mem_wb_mem_to_reg_sel), 32'h0);
        chk({tag, "_mis"}, 32'(mem_wb_misaligned), 32'h0);
    endtask

    task automatic drive(input instr_t in);
        ex_mem_valid          = in.valid;
        ex_mem_pc_4           = in.pc4;
        ex_mem_alu_result     = in.alu;
        ex_mem_rs2_data       = in.rs2;
        ex_mem_rd             = in.rd;
        ex_mem_reg_write_en   = in.rwe;
        ex_mem_mem_to_reg_sel = in.sel;
        ex_mem_mem_read       = in.rd_en;
        ex_mem_mem_write      = in.wr_en;
        ex_mem_funct3         = in.f3;
    endtask

    // One instruction through MEM; memory accepts after wait_n not-ready cycles.
    task automatic run(input instr_t in, input int wait_n, input logic [31:0] rdata);
        int          sz, a, cycles, stalls;
        logic        acc, mis, req, ld, st;
        logic [31:0] exp_be, exp_wd;
        sz     = ref_size(in.f3);
        a      = int'(in.alu[1:0]);
        acc    = in.valid & (in.rd_en | in.wr_en);
        mis    = acc && ((a % sz) != 0);
        req    = acc & ~mis;
        ld     = in.rd_en;
        st     = in.wr_en & ~in.rd_en;
        cycles = req ? wait_n : 0;
        stalls = 0;
        exp_be = ld ? 32'hF : 32'(((1 << sz) - 1) << (a - (a % sz)));
        exp_wd = (sz == 1) ? 32'(in.rs2[7:0]) * 32'h0101_0101 :
                 (sz == 2) ? 32'(in.rs2[15:0]) * 32'h0001_0001 : in.rs2;
        for (int c = 0; c <= cycles; c++) begin
            @(negedge clk);
            drive(in);
            dmem_ready = req ? (c == wait_n) : 1'($urandom);
            dmem_rdata = (c == cycles) ? rdata : $urandom;
            #1;
            chk("dmem_req", 32'(dmem_req), 32'(req));
            chk("mem_stall", 32'(mem_stall), 32'(req && c < wait_n));
            if (req) begin
                chk("dmem_addr", dmem_addr, in.alu & ~32'h3);
                chk("dmem_be", 32'(dmem_be), exp_be);
                chk("dmem_we", 32'(dmem_we), 32'(st));
                if (st) chk("dmem_wdata", dmem_wdata, exp_wd);
            end
            @(posedge clk);
            #1;
            if ((req && c < wait_n) || !in.valid) begin
                if (req && c < wait_n) stalls++;
                chk("bubble_rwe", 32'(mem_wb_reg_write_en), 32'h0);
                chk("bubble_mis", 32'(mem_wb_misaligned), 32'h0);
            end else begin
                chk("wb_pc4", mem_wb_pc_4, in.pc4);
                chk("wb_alu", mem_wb_alu_result, in.alu);
                chk("wb_rd", 32'(mem_wb_rd), 32'(in.rd));
                chk("wb_sel", 32'(mem_wb_mem_to_reg_sel), 32'(in.sel));
                chk("wb_rwe", 32'(mem_wb_reg_write_en), 32'(in.rwe & ~mis));
                chk("wb_mis", 32'(mem_wb_misaligned), 32'(mis));
                if (!mis)
                    chk("wb_rdata", mem_wb_mem_read_data, (acc && ld) ? ref_load(in.f3, a, rdata) : 32'h0);
            end
        end
        $display("txn v=%0d rd=%0d wr=%0d f3=%0d addr=%08h wait=%0d stalls=%0d wb_data=%08h",
                 in.valid, in.rd_en, in.wr_en, in.f3, in.alu, wait_n, stalls, mem_wb_mem_read_data);
    endtask

    function automatic instr_t mk(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                                  input logic [31:0] alu, input logic [31:0] rs2,
                                  input logic [4:0] rd, input logic rwe, input logic [1:0] sel);
        instr_t t;
        t.valid = 1'b1; t.pc4 = 32'h0000_1004; t.alu = alu; t.rs2 = rs2; t.rd = rd;
        t.rwe = rwe; t.sel = sel; t.rd_en = rd_en; t.wr_en = wr_en; t.f3 = f3;
        return t;
    endfunction

    initial begin
        instr_t t;
        rst = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        t = mk(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
        t.valid = 1'b0;
        drive(t);
        repeat (2) @(posedge clk);
        #1;
        check_wb_zero("reset");
        chk("reset_req", 32'(dmem_req), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // ALU op, lb/lbu sign handling, sh lanes, stalled lw, misaligned lw
        run(mk(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1, 2'b00), 0, 32'h0);
        run(mk(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 1'b1, 2'b01), 0, 32'h80FF_1122);
        run(mk(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 1'b1, 2'b01), 0, 32'h80FF_1122);
        run(mk(1'b0, 1'b1, 3'b001, 32'h202, 32'hAAAA_BEEF, 5'd0, 1'b0, 2'b00), 0, 32'h0);
        run(mk(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd8, 1'b1, 2'b01), 3, 32'hCAFE_F00D);
        run(mk(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 5'd9, 1'b1, 2'b01), 0, 32'h0);
        run(mk(1'b1, 1'b1, 3'b001, 32'h402, 32'h1357, 5'd10, 1'b1, 2'b01), 1, 32'h8765_4321);

        // Reset while waiting on memory
        @(negedge clk);
        drive(mk(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd11, 1'b1, 2'b01));
        dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("wait_stall", 32'(mem_stall), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_stall", 32'(mem_stall), 32'h0);
        @(posedge clk);
        #1;
        check_wb_zero("rst_wait");
        @(negedge clk);
        rst = 1'b0;
        ex_mem_valid = 1'b0;
        #1;
        chk("post_rst_req", 32'(dmem_req), 32'h0);
        chk("post_rst_stall", 32'(mem_stall), 32'h0);

        for (int i = 0; i < 300; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            t.valid = ($urandom_range(0, 9) != 0);
            t.pc4   = $urandom;
            t.alu   = $urandom;
            t.rs2   = $urandom;
            t.rd    = 5'($urandom);
            t.rwe   = 1'($urandom);
            t.sel   = 2'($urandom_range(0, 2));
            t.rd_en = (kind == 1) || (kind == 3);
            t.wr_en = (kind == 2) || (kind == 3);
            t.f3    = (kind == 2) ? 3'($urandom_range(0, 2)) : 3'($urandom);
            run(t, $urandom_range(0, 3), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
